clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//   Programmable clock divider placed directly downstream of the fixed divide-by-2 toggle stage.
//   It generates a divided clock (clk_out) and a one-cycle period tick from clk, dividing by
//   any runtime divisor N >= 2. With N = 2 it reproduces the 1,0,1,0 toggle pattern.
//   A new divisor is loaded through a valid/ready handshake and only takes effect at a
//   period boundary, so clk_out never produces a runt pulse on reconfiguration.
// PARAMETERS
//   WIDTH        8   width of the divisor and of the phase counter
//   DEFAULT_DIV  2   divisor after reset; legal range 2 .. 2^WIDTH-1
// PORTS
//   clk        in   1      system clock; all logic is on the rising edge
//   reset      in   1      synchronous, active-high reset
//   en         in   1      run enable; 0 holds clk_out low
//   div_in     in   WIDTH  requested divisor N
//   div_valid  in   1      div_in is valid this cycle
//   div_ready  out  1      block can accept a divisor this cycle
//   cfg_err    out  1      1-cycle pulse: the accepted div_in was illegal (0 or 1)
//   div_cur    out  WIDTH  divisor currently in effect
//   clk_out    out  1      divided clock (registered)
//   tick       out  1      1-cycle pulse coincident with each clk_out rising cycle
// BEHAVIOUR
//   Reset values (sync reset): state=IDLE, cnt=0, clk_out=0, tick=0, cfg_err=0,
//     div_cur=DEFAULT_DIV, div_ready=1. Any pending divisor is discarded.
//   Definitions: HI = ceil(N/2) = N - floor(N/2). The phase counter cnt runs 0..N-1.
//     For each registered value of cnt: clk_out <= (cnt < HI) and tick <= (cnt == 0).
//     All outputs are registered; there are no combinational paths from inputs to outputs
//     except div_ready, which is a decode of state.
//   States:
//     IDLE:    en=0; cnt=0; clk_out=0.
//     RUN:     counting.
//     PENDING: counting, with a legal divisor held in pend_div.
//   Transitions:
//     IDLE->RUN at the edge where en=1 is sampled. At that edge cnt<=0, clk_out<=1, tick<=1.
//       The first high cycle therefore starts one cycle after en rises.
//     RUN: each edge sets cnt <= (cnt==N-1) ? 0 : cnt+1.
//     RUN/PENDING->IDLE at the edge where en=0 is sampled. At that edge cnt<=0, clk_out<=0,
//       tick<=0. A high phase in progress is truncated.
//     From PENDING->IDLE, pend_div is copied into div_cur at the same edge.
//   Handshake:
//     div_ready = 1 in IDLE and RUN, and 0 in PENDING.
//     A transfer occurs when div_valid && div_ready are both 1 at a clock edge.
//     Illegal divisor (div_in < 2): at the transfer edge cfg_err<=1 for one cycle;
//       div_cur and state are unchanged.
//     Legal divisor in IDLE: div_cur<=div_in at the transfer edge.
//     Legal divisor in RUN: pend_div<=div_in and state moves to PENDING.
//     PENDING: at the wrap edge (cnt==N-1), div_cur<=pend_div, cnt<=0, clk_out<=1, tick<=1,
//       and state returns to RUN. The new N governs the whole new period;
//       div_ready is 1 in the cycle after the wrap.
//   Simultaneous events:
//     reset has priority over everything.
//     en=0 has priority over the wrap and over the handshake. A divisor offered while en=0
//       in RUN is treated as if in IDLE: it is applied at that edge if legal.
//     Transfer and wrap at the same edge in RUN: the old N completes, and the new N
//       applies at the next wrap.
//   Width rules:
//     cnt and the comparisons are unsigned WIDTH bits.
//     N = 2^WIDTH-1 gives a high phase of 2^(WIDTH-1) cycles and a low phase of
//       2^(WIDTH-1)-1 cycles; cnt never overflows.
// TESTING
//   T1 reset, en=1, N=2: clk_out 0,1,0,1,... from the cycle after en; tick every 2nd cycle,
//      aligned with clk_out=1.
//   T2 in IDLE, div_in=5 with valid: div_cur=5 next cycle; then en=1 gives clk_out pattern
//      1,1,1,0,0 repeating, tick period 5.
//   T3 RUN with N=4; send N=3 when cnt=1: div_ready=0 until the wrap; outputs 1,1,0,0 then
//      1,1,0 repeating; div_ready=1 one cycle after the wrap.
//   T4 div_in=0, then div_in=1: cfg_err pulses once per transfer; div_cur and clk_out are
//      unaffected.
//   T5 en dropped during the high phase with N=6: clk_out=0 next cycle. A pending N=3 is
//      applied at once. en re-raised gives the pattern 1,1,0.
//   T6 reset pulsed in PENDING with N=255 (WIDTH=8): after reset, clk_out=0, tick=0,
//      div_cur=2, div_ready=1; a separate N=255 run gives 128 high and 127 low cycles.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable clock divider: divides clk by a runtime divisor N >= 2, producing a
// registered divided clock and a one-cycle period tick. New divisors arrive over a
// valid/ready handshake and take effect only at a period boundary.
module clk_div_prog #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             cfg_err,
    output logic [WIDTH-1:0] div_cur,
    output logic             clk_out,
    output logic             tick
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nx;
    logic [WIDTH-1:0] pend_div;
    logic [WIDTH-1:0] pend_div_nx;
    logic [WIDTH-1:0] div_cur_nx;
    logic             clk_out_nx;
    logic             tick_nx;
    logic             cfg_err_nx;

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] last;
    logic             wrap;
    logic             legal;
    logic             xfer;
    logic             run_nx;

    // Ready is a pure decode of state: only a held pending divisor blocks new requests
    assign div_ready = (state != PENDING);

    // Period decode for the divisor in effect: high phase length and wrap point
    always_comb begin
        hi    = div_cur - (div_cur >> 1);
        last  = div_cur - WIDTH'(1);
        wrap  = (cnt == last);
        legal = (div_in >= WIDTH'(2));
        xfer  = div_valid && div_ready;
    end

    // Next-state, counter, divisor and output decode
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        div_cur_nx  = div_cur;
        pend_div_nx = pend_div;
        cfg_err_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = wrap ? '0 : cnt + WIDTH'(1);
                    // A legal divisor waits for the next wrap; the current period completes
                    if (xfer && legal) begin
                        state_nx    = PENDING;
                        pend_div_nx = div_in;
                    end
                end
            end
            PENDING: begin
                if (!en) begin
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    div_cur_nx = pend_div;
                end else if (wrap) begin
                    state_nx   = RUN;
                    cnt_nx     = '0;
                    div_cur_nx = pend_div;
                end else begin
                    cnt_nx = cnt + WIDTH'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        // Idle, or running with en low, applies a legal divisor immediately
        if (xfer) begin
            if (!legal) begin
                cfg_err_nx = 1'b1;
            end else if (state == IDLE || !en) begin
                div_cur_nx = div_in;
            end
        end

        // cnt_nx is 0 whenever div_cur changes, so using the old divisor for hi is safe
        run_nx     = (state_nx != IDLE);
        clk_out_nx = run_nx && (cnt_nx < hi);
        tick_nx    = run_nx && (cnt_nx == '0);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            pend_div <= '0;
            div_cur  <= WIDTH'(DEFAULT_DIV);
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            pend_div <= pend_div_nx;
            div_cur  <= div_cur_nx;
            clk_out  <= clk_out_nx;
            tick     <= tick_nx;
            cfg_err  <= cfg_err_nx;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: patterns, handshake, illegal divisors, en drop, reset.
module tb_clk_div_prog;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             div_valid;
    logic             div_ready;
    logic             cfg_err;
    logic [WIDTH-1:0] div_cur;
    logic             clk_out;
    logic             tick;

    int checks;
    int failures;

    clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .div_in    (div_in),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .cfg_err   (cfg_err),
        .div_cur   (div_cur),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; inputs change and outputs are sampled here
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_idle(input logic [WIDTH-1:0] n);
        div_in = n; div_valid = 1'b1;
        cyc();
        div_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; div_in = '0; div_valid = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL reset_clk_out got=%b want=0", clk_out); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b want=0", tick); end
        checks++; if (div_cur !== 8'd2) begin failures++; $display("FAIL reset_div_cur got=%0d want=2", div_cur); end
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL reset_div_ready got=%b want=1", div_ready); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b want=0", cfg_err); end
    endtask

    task automatic test_div2();
        logic exp;
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            exp = (i % 2 == 0);
            checks++; if (clk_out !== exp) begin failures++; $display("FAIL div2_clk_out[%0d] got=%b want=%b", i, clk_out, exp); end
            checks++; if (tick !== exp) begin failures++; $display("FAIL div2_tick[%0d] got=%b want=%b", i, tick, exp); end
        end
        en = 1'b0;
        cyc();
        checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL div2_stop got=%b want=0", clk_out); end
    endtask

    task automatic test_div5();
        logic exp_c, exp_t;
        load_idle(8'd5);
        checks++; if (div_cur !== 8'd5) begin failures++; $display("FAIL div5_load got=%0d want=5", div_cur); end
        checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL div5_idle_clk got=%b want=0", clk_out); end
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            exp_c = ((i % 5) < 3);
            exp_t = ((i % 5) == 0);
            checks++; if (clk_out !== exp_c) begin failures++; $display("FAIL div5_clk_out[%0d] got=%b want=%b", i, clk_out, exp_c); end
            checks++; if (tick !== exp_t) begin failures++; $display("FAIL div5_tick[%0d] got=%b want=%b", i, tick, exp_t); end
        end
        en = 1'b0;
        cyc();
    endtask

    task automatic test_pending();
        logic exp_c;
        load_idle(8'd4);
        en = 1'b1;
        cyc();                       // cnt=0
        cyc();                       // cnt=1
        div_in = 8'd3; div_valid = 1'b1;
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL pend_ready_before got=%b want=1", div_ready); end
        cyc();                       // transfer, cnt=2
        div_valid = 1'b0;
        checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL pend_ready_held got=%b want=0", div_ready); end
        checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL pend_clk_c2 got=%b want=0", clk_out); end
        checks++; if (div_cur !== 8'd4) begin failures++; $display("FAIL pend_div_old got=%0d want=4", div_cur); end
        cyc();                       // cnt=3
        checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL pend_ready_c3 got=%b want=0", div_ready); end
        checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL pend_clk_c3 got=%b want=0", clk_out); end
        cyc();                       // wrap into N=3
        checks++; if (div_cur !== 8'd3) begin failures++; $display("FAIL pend_div_new got=%0d want=3", div_cur); end
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL pend_ready_after got=%b want=1", div_ready); end
        checks++; if (tick !== 1'b1) begin failures++; $display("FAIL pend_wrap_tick got=%b want=1", tick); end
        checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL pend_wrap_clk got=%b want=1", clk_out); end
        for (int i = 1; i < 7; i++) begin
            cyc();
            exp_c = ((i % 3) < 2);
            checks++; if (clk_out !== exp_c) begin failures++; $display("FAIL pend_n3_clk[%0d] got=%b want=%b", i, clk_out, exp_c); end
        end
        en = 1'b0;
        cyc();
    endtask

    task automatic test_cfg_err();
        en = 1'b1;
        cyc();                       // cnt=0, N=3
        div_in = 8'd0; div_valid = 1'b1;
        cyc();                       // cnt=1
        div_valid = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL err0_pulse got=%b want=1", cfg_err); end
        checks++; if (div_cur !== 8'd3) begin failures++; $display("FAIL err0_div got=%0d want=3", div_cur); end
        checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL err0_clk got=%b want=1", clk_out); end
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL err0_ready got=%b want=1", div_ready); end
        cyc();                       // cnt=2
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL err0_single got=%b want=0", cfg_err); end
        checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL err0_clk2 got=%b want=0", clk_out); end
        div_in = 8'd1; div_valid = 1'b1;
        cyc();                       // wrap, cnt=0
        div_valid = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL err1_pulse got=%b want=1", cfg_err); end
        checks++; if (tick !== 1'b1) begin failures++; $display("FAIL err1_tick got=%b want=1", tick); end
        checks++; if (div_cur !== 8'd3) begin failures++; $display("FAIL err1_div got=%0d want=3", div_cur); end
        cyc();
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL err1_single got=%b want=0", cfg_err); end
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL err1_ready got=%b want=1", div_ready); end
        en = 1'b0;
        cyc();
    endtask

    task automatic test_en_drop();
        logic exp_c;
        load_idle(8'd6);
        en = 1'b1;
        cyc();                       // cnt=0
        cyc();                       // cnt=1
        div_in = 8'd3; div_valid = 1'b1;
        cyc();                       // pending, cnt=2 still high
        div_valid = 1'b0;
        checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL drop_high got=%b want=1", clk_out); end
        checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL drop_pend got=%b want=0", div_ready); end
        en = 1'b0;
        cyc();
        checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL drop_clk got=%b want=0", clk_out); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL drop_tick got=%b want=0", tick); end
        checks++; if (div_cur !== 8'd3) begin failures++; $display("FAIL drop_apply got=%0d want=3", div_cur); end
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL drop_ready got=%b want=1", div_ready); end
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            exp_c = ((i % 3) < 2);
            checks++; if (clk_out !== exp_c) begin failures++; $display("FAIL drop_n3_clk[%0d] got=%b want=%b", i, clk_out, exp_c); end
        end
        // Divisor offered together with en low while running is applied at once
        en = 1'b0; div_in = 8'd7; div_valid = 1'b1;
        cyc();
        div_valid = 1'b0;
        checks++; if (div_cur !== 8'd7) begin failures++; $display("FAIL drop_offer got=%0d want=7", div_cur); end
        checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL drop_offer_clk got=%b want=0", clk_out); end
    endtask

    task automatic test_reset_pending();
        int highs, lows, ticks;
        en = 1'b1;
        cyc();
        div_in = 8'd255; div_valid = 1'b1;
        cyc();
        div_valid = 1'b0;
        checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL rstp_pend got=%b want=0", div_ready); end
        reset = 1'b1; en = 1'b0;
        cyc();
        reset = 1'b0;
        checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL rstp_clk got=%b want=0", clk_out); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL rstp_tick got=%b want=0", tick); end
        checks++; if (div_cur !== 8'd2) begin failures++; $display("FAIL rstp_div got=%0d want=2", div_cur); end
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL rstp_ready got=%b want=1", div_ready); end
        cyc();
        checks++; if (div_cur !== 8'd2) begin failures++; $display("FAIL rstp_discard got=%0d want=2", div_cur); end
        load_idle(8'd255);
        en = 1'b1;
        highs = 0; lows = 0; ticks = 0;
        for (int i = 0; i < 255; i++) begin
            cyc();
            if (clk_out === 1'b1) highs++; else lows++;
            if (tick === 1'b1) ticks++;
            checks++; if (clk_out !== (i < 128)) begin failures++; $display("FAIL n255_clk[%0d] got=%b want=%b", i, clk_out, (i < 128)); end
        end
        checks++; if (highs != 128) begin failures++; $display("FAIL n255_highs got=%0d want=128", highs); end
        checks++; if (lows != 127) begin failures++; $display("FAIL n255_lows got=%0d want=127", lows); end
        checks++; if (ticks != 1) begin failures++; $display("FAIL n255_ticks got=%0d want=1", ticks); end
        cyc();
        checks++; if (tick !== 1'b1) begin failures++; $display("FAIL n255_wrap_tick got=%b want=1", tick); end
        en = 1'b0;
        cyc();
    endtask

    task automatic test_back_to_back();
        load_idle(8'd2);
        en = 1'b1;
        cyc();                       // cnt=0
        cyc();                       // cnt=1
        div_in = 8'd4; div_valid = 1'b1;
        cyc();                       // transfer and wrap together
        div_valid = 1'b0;
        checks++; if (div_cur !== 8'd2) begin failures++; $display("FAIL b2b_div_old got=%0d want=2", div_cur); end
        checks++; if (tick !== 1'b1) begin failures++; $display("FAIL b2b_tick got=%b want=1", tick); end
        checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL b2b_pend got=%b want=0", div_ready); end
        cyc();                       // old N=2 period finishes
        checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL b2b_old_low got=%b want=0", clk_out); end
        cyc();                       // wrap into N=4
        checks++; if (div_cur !== 8'd4) begin failures++; $display("FAIL b2b_div_new got=%0d want=4", div_cur); end
        cyc();
        checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL b2b_new_high got=%b want=1", clk_out); end
        cyc();
        checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL b2b_new_low got=%b want=0", clk_out); end
        en = 1'b0;
        cyc();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1; en = 1'b0; div_in = '0; div_valid = 1'b0;
        test_reset();
        test_div2();
        test_div5();
        test_pending();
        test_cfg_err();
        test_en_drop();
        test_reset_pending();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
